stream_mux_rr: RTL



---
 rtl/stream_mux_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/stream_mux_rr.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// ---------------------------------------------------------------------------
// stream_mux_pkg
// Shared types and helpers for the round-robin stream multiplexer.
//   mux_mode_e  : arbitration mode (round-robin or fixed select)
//   mux_state_e : output register occupancy
//   ch_w()      : channel-index width for a given channel count (min 1 bit)
// ---------------------------------------------------------------------------
package stream_mux_pkg;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } mux_mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } mux_state_e;

  // $clog2(1) is 0, which would give a zero-width index; keep at least 1 bit.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational rotating-priority encoder. The channel just after
// 'last' has the highest priority, wrapping from NUM_CH-1 back to 0.
// Ports:
//   req       in  NUM_CH  request vector (one bit per channel)
//   last      in  CH_W    index of the most recently served channel
//   grant_oh  out NUM_CH  one-hot grant (all zero when nothing requests)
//   grant_idx out CH_W    index of the granted channel
//   grant_vld out 1       a grant exists
// ---------------------------------------------------------------------------
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last,
  output logic [NUM_CH-1:0] grant_oh,
  output logic [CH_W-1:0]   grant_idx,
  output logic              grant_vld
);

  int w_dist;
  int w_best;

  // Each channel gets a distance from last+1 (mod NUM_CH); the requesting
  // channel with the smallest distance wins. The 2*NUM_CH bias keeps the
  // modulo operand non-negative for every possible 'last' value.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    w_best    = NUM_CH;
    w_dist    = 0;
    for (int j = 0; j < NUM_CH; j++) begin
      w_dist = (j - int'(last) - 1 + 2 * NUM_CH) % NUM_CH;
      if (req[j] && (w_dist < w_best)) begin
        w_best    = w_dist;
        grant_idx = CH_W'(j);
        grant_vld = 1'b1;
      end
    end
  end

  assign grant_oh = grant_vld ? (NUM_CH'(1) << grant_idx) : '0;

endmodule

// File: rtl/stream_mux_rr.sv
// ---------------------------------------------------------------------------
// stream_mux_rr
// N-channel valid/ready stream multiplexer with round-robin or fixed-select
// arbitration and a single registered output stage tagged with the source
// channel. Sustains one word per cycle when the consumer is always ready.
// Ports:
//   clk        in  1              rising-edge clock
//   rst_n      in  1              synchronous active-low reset
//   mode       in  1              0 = round-robin, 1 = fixed select
//   sel        in  CH_W           channel served in fixed mode
//   in_valid   in  NUM_CH         per-channel valid
//   in_data    in  NUM_CH*DATA_W  packed data, ch i at [i*DATA_W +: DATA_W]
//   in_ready   out NUM_CH         per-channel ready (at most one bit high)
//   out_valid  out 1              output word valid
//   out_data   out DATA_W         output word
//   out_ch     out CH_W           source channel of out_data
//   out_ready  in  1              consumer ready
// ---------------------------------------------------------------------------
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 8,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [CH_W-1:0]          sel,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready
);

  // sel can address 2**CH_W channels; the extra slots read as "not valid".
  localparam int SEL_SPAN = 1 << CH_W;

  mux_state_e          r_state;
  mux_state_e          w_state_nxt;
  logic [CH_W-1:0]     r_last;
  logic [DATA_W-1:0]   r_data;
  logic [CH_W-1:0]     r_ch;

  mux_mode_e           w_mode;
  logic [NUM_CH-1:0]   w_rr_oh;
  logic [CH_W-1:0]     w_rr_idx;
  logic                w_rr_vld;
  logic [SEL_SPAN-1:0] w_valid_ext;
  logic                w_fix_vld;
  logic [NUM_CH-1:0]   w_grant_oh;
  logic [CH_W-1:0]     w_grant_idx;
  logic                w_grant_vld;
  logic                w_load_en;
  logic                w_xfer;
  logic [DATA_W-1:0]   w_sel_data;

  assign w_mode = mux_mode_e'(mode);

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req       (in_valid),
    .last      (r_last),
    .grant_oh  (w_rr_oh),
    .grant_idx (w_rr_idx),
    .grant_vld (w_rr_vld)
  );

  // Zero-extending the valid vector makes out-of-range sel values (only
  // possible for non-power-of-2 NUM_CH) produce no grant.
  assign w_valid_ext = SEL_SPAN'(in_valid);
  assign w_fix_vld   = w_valid_ext[sel];

  always_comb begin
    w_grant_oh  = '0;
    w_grant_idx = '0;
    w_grant_vld = 1'b0;
    if (w_mode == MODE_FIXED) begin
      w_grant_vld = w_fix_vld;
      w_grant_idx = sel;
      if (w_fix_vld) begin
        w_grant_oh = NUM_CH'(1) << sel;
      end
    end else begin
      w_grant_vld = w_rr_vld;
      w_grant_idx = w_rr_idx;
      w_grant_oh  = w_rr_oh;
    end
  end

  // The output register can take a new word when it is empty or when its
  // current word leaves this cycle. Gating with rst_n keeps every in_ready
  // low during reset so no producer believes a word was taken.
  assign w_load_en = (r_state == ST_EMPTY) | out_ready;
  assign w_xfer    = rst_n & w_load_en & w_grant_vld;
  assign in_ready  = w_xfer ? w_grant_oh : '0;

  always_comb begin
    w_sel_data = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (CH_W'(j) == w_grant_idx) begin
        w_sel_data = in_data[j*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_xfer) begin
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        // A reload in the same cycle keeps the stage full (back-to-back).
        if (out_ready && !w_xfer) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output register: a held word is discarded by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= '0;
      r_ch   <= '0;
    end else if (w_xfer) begin
      r_data <= w_sel_data;
      r_ch   <= w_grant_idx;
    end
  end

  // The pointer moves only on an actual round-robin transfer, so a stalled
  // grant stays on the same channel until it is taken. Reset value makes
  // channel 0 the first in line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= CH_W'(NUM_CH - 1);
    end else if (w_xfer && (w_mode == MODE_RR)) begin
      r_last <= w_grant_idx;
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_ch    = r_ch;

endmodule
